// File: rtl/red_pitaya_led_pkg.sv
// Shared definitions for the LED heartbeat block: FSM state encoding,
// pattern codes and small decode helpers used by the pattern engine.
package red_pitaya_led_pkg;

    // Pattern engine states
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ON1  = 3'd1,
        ST_OFF1 = 3'd2,
        ST_ON2  = 3'd3,
        ST_REST = 3'd4
    } led_state_t;

    // LED pattern selection codes as presented on pattern_i
    localparam logic [1:0] PAT_OFF   = 2'd0;
    localparam logic [1:0] PAT_ON    = 2'd1;
    localparam logic [1:0] PAT_BLINK = 2'd2;
    localparam logic [1:0] PAT_HEART = 2'd3;

    // Width of the REST tick counter (REST_TICKS is limited to 1..255)
    localparam int unsigned REST_CNT_W = 8;

    // State a pattern starts in when it is (re)selected or leaves IDLE
    function automatic led_state_t first_state(input logic [1:0] pat);
        return (pat == PAT_OFF) ? ST_IDLE : ST_ON1;
    endfunction

    // LED level requested by a state, before any brightness modulation
    function automatic logic state_led(input led_state_t st);
        return (st == ST_ON1) || (st == ST_ON2);
    endfunction

endpackage

// File: rtl/red_pitaya_toggle_sync.sv
// Synchroniser and edge detector for the divided-clock toggle.
// toggle_i is asynchronous; it passes through SYNC_STAGES flops, an edge
// register compares the synchronised level with its previous value, and the
// result is registered once more onto tick_o. Every level change of toggle_i
// that is sampled therefore yields exactly one tick_o cycle, SYNC_STAGES+1
// cycles after the posedge that first samples the new level.
module red_pitaya_toggle_sync
    import red_pitaya_led_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rstn_i,
    input  logic toggle_i,
    output logic tick_o
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic                   r_edge;
    logic                   r_tick;
    logic                   w_sync_last;

    assign w_sync_last = r_sync[SYNC_STAGES-1];

    // Synchronise toggle_i, detect either edge, register the tick pulse
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            r_sync <= '0;
            r_prev <= 1'b0;
            r_edge <= 1'b0;
            r_tick <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], toggle_i};
            r_prev <= w_sync_last;
            r_edge <= w_sync_last ^ r_prev;
            r_tick <= r_edge;
        end
    end

    assign tick_o = r_tick;

endmodule

// File: rtl/red_pitaya_led_heartbeat.sv
// Status LED pattern engine driven by the clock-divider toggle.
// Each toggle edge becomes a one-cycle tick; ticks advance an FSM producing
// off / steady / blink / heartbeat double-blink on led_o, and completed
// heartbeat periods are counted on beat_cnt_o.
// Optional feature: define RED_PITAYA_LED_PWM_EN to modulate led_o with a
// free-running PWM counter compared against duty_i. Without the macro,
// duty_i is ignored and led_o follows the FSM directly (registered).
module red_pitaya_led_heartbeat
    import red_pitaya_led_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned REST_TICKS  = 5,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned PWM_W       = 8
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             toggle_i,
    input  logic             enable_i,
    input  logic [1:0]       pattern_i,
    input  logic [PWM_W-1:0] duty_i,
    output logic             tick_o,
    output logic             led_o,
    output logic [CNT_W-1:0] beat_cnt_o
);

    // Last REST tick index: the tick seen at this count leaves REST
    localparam logic [REST_CNT_W-1:0] REST_LAST = REST_CNT_W'(REST_TICKS - 1);

    logic                  w_tick;
    logic                  w_led_raw;
    led_state_t            r_state;
    logic [1:0]            r_pat;
    logic [REST_CNT_W-1:0] r_rest;
    logic [CNT_W-1:0]      r_beat;
    logic                  r_led;

    red_pitaya_toggle_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_toggle_sync (
        .clk_i    (clk_i),
        .rstn_i   (rstn_i),
        .toggle_i (toggle_i),
        .tick_o   (w_tick)
    );

    // Pattern FSM: moves only on ticks while enabled; a pattern change (or
    // leaving IDLE) restarts the newly selected pattern from its first state
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            r_state <= ST_IDLE;
            r_pat   <= PAT_OFF;
            r_rest  <= '0;
            r_beat  <= '0;
        end else if (!enable_i) begin
            r_state <= ST_IDLE;
            r_rest  <= '0;
        end else if (w_tick) begin
            if ((r_state == ST_IDLE) || (pattern_i != r_pat)) begin
                r_state <= first_state(pattern_i);
                r_pat   <= pattern_i;
                r_rest  <= '0;
            end else begin
                case (r_state)
                    ST_ON1: begin
                        // steady-on holds ON1; blink and heartbeat move on
                        if ((r_pat == PAT_BLINK) || (r_pat == PAT_HEART)) begin
                            r_state <= ST_OFF1;
                        end
                    end
                    ST_OFF1: begin
                        r_state <= (r_pat == PAT_HEART) ? ST_ON2 : ST_ON1;
                    end
                    ST_ON2: begin
                        r_state <= ST_REST;
                        r_rest  <= '0;
                    end
                    ST_REST: begin
                        if (r_rest == REST_LAST) begin
                            r_state <= ST_ON1;
                            r_rest  <= '0;
                            r_beat  <= r_beat + 1'b1;
                        end else begin
                            r_rest  <= r_rest + 1'b1;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_rest  <= '0;
                    end
                endcase
            end
        end
    end

    assign w_led_raw = state_led(r_state);

`ifdef RED_PITAYA_LED_PWM_EN
    logic [PWM_W-1:0] r_pwm;

    // Free-running PWM counter
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            r_pwm <= '0;
        end else begin
            r_pwm <= r_pwm + 1'b1;
        end
    end

    // LED output: FSM level gated by the PWM duty comparison
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            r_led <= 1'b0;
        end else begin
            r_led <= w_led_raw & (r_pwm < duty_i);
        end
    end
`else
    logic w_unused_duty;
    assign w_unused_duty = ^duty_i;

    // LED output: registered FSM level
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            r_led <= 1'b0;
        end else begin
            r_led <= w_led_raw;
        end
    end
`endif

    assign tick_o     = w_tick;
    assign led_o      = r_led;
    assign beat_cnt_o = r_beat;

endmodule

// File: tb/tb_red_pitaya_led_heartbeat.sv
// Self-checking bench for red_pitaya_led_heartbeat.
// A behavioural model (sample history for ticks, pattern position for the
// LED, period counter for beats) is compared with the DUT every cycle;
// directed sequences add hand-computed expectations.
module tb_red_pitaya_led_heartbeat;

    localparam int SYNC = 2;
    localparam int REST = 5;
    localparam int CW   = 4;   // narrow beat counter so wrap-around is reachable
    localparam int PW   = 8;
    localparam int HL   = 3 + REST;  // heartbeat period in ticks

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          toggle = 1'b0;
    logic          enable = 1'b0;
    logic [1:0]    pattern = 2'd0;
    logic [PW-1:0] duty = '0;
    logic          tick;
    logic          led;
    logic [CW-1:0] beat;

    always #5 clk = ~clk;

    red_pitaya_led_heartbeat #(
        .SYNC_STAGES (SYNC),
        .REST_TICKS  (REST),
        .CNT_W       (CW),
        .PWM_W       (PW)
    ) dut (
        .clk_i      (clk),
        .rstn_i     (rstn),
        .toggle_i   (toggle),
        .enable_i   (enable),
        .pattern_i  (pattern),
        .duty_i     (duty),
        .tick_o     (tick),
        .led_o      (led),
        .beat_cnt_o (beat)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [4:0]    m_hist = '0;   // toggle samples, [0] = most recent edge
    logic          m_led = 1'b0;
    logic [CW-1:0] m_beat = '0;
    bit            m_active = 1'b0;
    logic [1:0]    m_cur = 2'd0;
    int            m_pos = 0;     // position within the running pattern
    logic [PW-1:0] m_p = '0;
    bit            chk_en = 1'b0;
    logic          mt;

    // a tick appears when the level sampled 3 edges ago differs from the one before
    assign mt = m_hist[3] ^ m_hist[4];

    function automatic logic raw_led(input bit act, input logic [1:0] cur, input int pos);
        if (!act) return 1'b0;
        case (cur)
            2'd1:    return 1'b1;
            2'd2:    return pos == 0;
            2'd3:    return (pos == 0) || (pos == 2);
            default: return 1'b0;
        endcase
    endfunction

    always @(posedge clk) begin
        if (!rstn) begin
            m_hist   <= '0;
            m_led    <= 1'b0;
            m_beat   <= '0;
            m_active <= 1'b0;
            m_cur    <= 2'd0;
            m_pos    <= 0;
            m_p      <= '0;
            chk_en   <= 1'b1;
        end else begin
            m_hist <= {m_hist[3:0], toggle};
            m_p    <= m_p + 1'b1;
`ifdef RED_PITAYA_LED_PWM_EN
            m_led  <= raw_led(m_active, m_cur, m_pos) & (m_p < duty);
`else
            m_led  <= raw_led(m_active, m_cur, m_pos);
`endif
            if (!enable) begin
                m_active <= 1'b0;
                m_pos    <= 0;
            end else if (mt) begin
                if (!m_active || (pattern != m_cur)) begin
                    m_cur    <= pattern;
                    m_active <= (pattern != 2'd0);
                    m_pos    <= 0;
                end else if (m_cur == 2'd2) begin
                    m_pos <= 1 - m_pos;
                end else if (m_cur == 2'd3) begin
                    if (m_pos == HL - 1) begin
                        m_pos  <= 0;
                        m_beat <= m_beat + 1'b1;
                    end else begin
                        m_pos <= m_pos + 1;
                    end
                end
            end
        end
    end

    // every-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            check("model_tick", {31'd0, tick}, {31'd0, mt});
            check("model_led",  {31'd0, led},  {31'd0, m_led});
            check("model_beat", 32'(beat),     32'(m_beat));
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // one toggle edge, then wait until the FSM move has reached led_o
    task automatic do_tick();
        toggle = ~toggle;
        cyc(6);
    endtask

    // watch a window after a toggle change; report first tick cycle and tick count
    task automatic watch(input int n, output int lat, output int cnt);
        lat = -1;
        cnt = 0;
        for (int k = 1; k <= n; k++) begin
            @(posedge clk);
            #1;
            if (tick === 1'b1) begin
                cnt++;
                if (lat < 0) lat = k - 1;
            end
        end
    endtask

    logic [7:0] hb_exp;
    logic [5:0] bl_exp;
    int lat;
    int cnt;
    int cnt_total;
    int highs;

    initial begin
        hb_exp = 8'b0000_0101;   // bit i = LED after heartbeat tick i+1
        bl_exp = 6'b01_0101;     // bit i = LED after blink tick i+1

        // 1: reset with toggle active
        rstn = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            toggle = ~toggle;
            cyc(1);
        end
        check("rst_tick", {31'd0, tick}, 32'd0);
        check("rst_led",  {31'd0, led},  32'd0);
        check("rst_beat", 32'(beat),     32'd0);
        rstn = 1'b1;
        cyc(6);

        // 2: tick latency on rising and falling toggle edges
        enable = 1'b0;
        toggle = 1'b1;
        watch(30, lat, cnt);
        check("tick_lat_rise", lat, 32'd3);
        cnt_total = cnt;
        toggle = 1'b0;
        watch(30, lat, cnt);
        check("tick_lat_fall", lat, 32'd3);
        cnt_total += cnt;
        check("tick_count", cnt_total, 32'd2);

        // 3: heartbeat, 17 ticks
        enable  = 1'b1;
        pattern = 2'd3;
        duty    = '1;
        for (int i = 0; i < 17; i++) begin
            do_tick();
`ifndef RED_PITAYA_LED_PWM_EN
            check("hb_led", {31'd0, led}, {31'd0, hb_exp[i % 8]});
`endif
            if (i == 7)  check("hb_beat_8",  32'(beat), 32'd0);
            if (i == 8)  check("hb_beat_9",  32'(beat), 32'd1);
            if (i == 16) check("hb_beat_17", 32'(beat), 32'd2);
        end

        // 4: blink, then disable mid-ON1
        pattern = 2'd2;
        for (int i = 0; i < 6; i++) begin
            do_tick();
`ifndef RED_PITAYA_LED_PWM_EN
            check("blink_led", {31'd0, led}, {31'd0, bl_exp[i]});
`endif
        end
        do_tick();
`ifndef RED_PITAYA_LED_PWM_EN
        check("blink_on1", {31'd0, led}, 32'd1);
`endif
        enable = 1'b0;
        cyc(1);
`ifndef RED_PITAYA_LED_PWM_EN
        check("dis_led_1", {31'd0, led}, 32'd1);
`endif
        cyc(1);
        check("dis_led_2", {31'd0, led}, 32'd0);
        check("dis_beat",  32'(beat), 32'd2);

        // 5: beat counter wrap
        enable  = 1'b1;
        pattern = 2'd3;
        for (int i = 0; i < 1 + HL * 13; i++) do_tick();
        check("wrap_allones", 32'(beat), 32'hF);
        for (int i = 0; i < HL; i++) do_tick();
        check("wrap_zero", 32'(beat), 32'd0);

        // 6: brightness
`ifdef RED_PITAYA_LED_PWM_EN
        pattern = 2'd1;
        duty    = 8'd64;
        do_tick();
        highs = 0;
        for (int i = 0; i < 256; i++) begin
            cyc(1);
            if (led === 1'b1) highs++;
        end
        check("pwm_64", highs, 32'd64);
        duty = 8'd0;
        cyc(2);
        highs = 0;
        for (int i = 0; i < 256; i++) begin
            cyc(1);
            if (led === 1'b1) highs++;
        end
        check("pwm_0", highs, 32'd0);
`else
        pattern = 2'd1;
        duty    = 8'd0;
        do_tick();
        highs = 0;
        for (int i = 0; i < 20; i++) begin
            cyc(1);
            if (led === 1'b1) highs++;
        end
        check("steady_on", highs, 32'd20);
`endif

        // 7: randomized traffic with a mid-run reset
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            #1;
            if ($urandom_range(0, 4) == 0) toggle = ~toggle;
            if ($urandom_range(0, 39) == 0) pattern = 2'($urandom_range(0, 3));
            if (enable && ($urandom_range(0, 59) == 0)) enable = 1'b0;
            else if (!enable && ($urandom_range(0, 7) == 0)) enable = 1'b1;
            if ($urandom_range(0, 49) == 0) duty = PW'($urandom);
            if (i == 1500) rstn = 1'b0;
            if (i == 1502) rstn = 1'b1;
        end
        cyc(10);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
